i2c_bus_filter: RTL and testbench

I2C_BUS_FILTER -- requirements
Module: i2c_bus_filter

---
 rtl/i2c_bus_filter_if.sv | 31 +++
 rtl/i2c_bus_filter.sv | 115 +++++++++++
 tb/tb_i2c_bus_filter.sv | 360 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/i2c_bus_filter_if.sv
// Bus-side signal bundle for the I2C input filter.
// No valid/ready pairs travel on this interface. scl_i/sda_i are raw
// asynchronous pad levels. scl_f_o/sda_f_o/busy_o are registered levels.
// scl_rise_o, scl_fall_o, start_o, stop_o and sample_o are one-cycle strobes
// with no back-pressure: a consumer that misses one has missed the event.
interface i2c_bus_filter_if;
  logic scl_i;
  logic sda_i;
  logic scl_f_o;
  logic sda_f_o;
  logic scl_rise_o;
  logic scl_fall_o;
  logic start_o;
  logic stop_o;
  logic busy_o;
  logic sample_o;

  // Pad / controller side: drives the raw lines, consumes filtered results.
  modport master (
    output scl_i, sda_i,
    input  scl_f_o, sda_f_o, scl_rise_o, scl_fall_o,
    input  start_o, stop_o, busy_o, sample_o
  );

  // Filter side: consumes raw lines, produces filtered levels and events.
  modport slave (
    input  scl_i, sda_i,
    output scl_f_o, sda_f_o, scl_rise_o, scl_fall_o,
    output start_o, stop_o, busy_o, sample_o
  );
endinterface

// File: rtl/i2c_bus_filter.sv
// I2C pad input filter: synchronizes SCL/SDA, samples them every P cycles,
// takes a 3-sample majority vote, and derives SCL edges, START/STOP and busy.
module i2c_bus_filter #(
  parameter int DFSR_W = 16
) (
  input  logic              sysclk_i,
  input  logic              reset_i,
  input  logic              enable_i,
  input  logic [DFSR_W-1:0] dfsr_i,
  i2c_bus_filter_if.slave   bus
);

  // Bit [1] is the second synchronizer flop, the only value used downstream.
  logic [1:0]        scl_sync_q;
  logic [1:0]        sda_sync_q;
  logic [DFSR_W-1:0] cnt_q;
  logic [DFSR_W-1:0] reload_val;
  logic              sample_en;
  // The two previous samples; with the current synchronized value they form
  // the 3-sample window the majority vote looks at.
  logic [1:0]        scl_hist_q;
  logic [1:0]        sda_hist_q;
  logic              scl_maj;
  logic              sda_maj;
  logic              scl_f_q;
  logic              sda_f_q;
  logic              scl_rise_q;
  logic              scl_fall_q;
  logic              start_q;
  logic              stop_q;
  logic              busy_q;
  logic              sample_q;

  // Reload value P-1 where P = max(dfsr_i, 1); a counter value of 0 is a sample.
  always_comb begin
    reload_val = (dfsr_i == '0) ? '0 : dfsr_i - DFSR_W'(1);
    sample_en  = enable_i && (cnt_q == '0);
    scl_maj    = (scl_sync_q[1] & scl_hist_q[0]) | (scl_sync_q[1] & scl_hist_q[1])
               | (scl_hist_q[0] & scl_hist_q[1]);
    sda_maj    = (sda_sync_q[1] & sda_hist_q[0]) | (sda_sync_q[1] & sda_hist_q[1])
               | (sda_hist_q[0] & sda_hist_q[1]);
  end

  // Two-flop synchronizers for the asynchronous pad inputs.
  always_ff @(posedge sysclk_i) begin
    if (reset_i) begin
      scl_sync_q <= 2'b11;
      sda_sync_q <= 2'b11;
    end else begin
      scl_sync_q <= {scl_sync_q[0], bus.scl_i};
      sda_sync_q <= {sda_sync_q[0], bus.sda_i};
    end
  end

  // Sample-period down-counter; dfsr_i is only looked at when reloading.
  always_ff @(posedge sysclk_i) begin
    if (reset_i || !enable_i) begin
      cnt_q <= reload_val;
    end else if (cnt_q == '0) begin
      cnt_q <= reload_val;
    end else begin
      cnt_q <= cnt_q - DFSR_W'(1);
    end
  end

  // Majority filter plus edge / condition detection, all on the sample edge.
  always_ff @(posedge sysclk_i) begin
    if (reset_i || !enable_i) begin
      scl_hist_q <= 2'b11;
      sda_hist_q <= 2'b11;
      scl_f_q    <= 1'b1;
      sda_f_q    <= 1'b1;
      scl_rise_q <= 1'b0;
      scl_fall_q <= 1'b0;
      start_q    <= 1'b0;
      stop_q     <= 1'b0;
      sample_q   <= 1'b0;
    end else begin
      sample_q   <= sample_en;
      scl_rise_q <= sample_en && scl_maj && !scl_f_q;
      scl_fall_q <= sample_en && !scl_maj && scl_f_q;
      // SCL must be high both before and after the sample, which also rules
      // out a condition when SCL and SDA move on the same sample.
      start_q    <= sample_en && scl_f_q && scl_maj && sda_f_q && !sda_maj;
      stop_q     <= sample_en && scl_f_q && scl_maj && !sda_f_q && sda_maj;
      if (sample_en) begin
        scl_hist_q <= {scl_hist_q[0], scl_sync_q[1]};
        sda_hist_q <= {sda_hist_q[0], sda_sync_q[1]};
        scl_f_q    <= scl_maj;
        sda_f_q    <= sda_maj;
      end
    end
  end

  // Bus busy flag follows the registered START/STOP pulses by one cycle.
  always_ff @(posedge sysclk_i) begin
    if (reset_i || !enable_i) begin
      busy_q <= 1'b0;
    end else if (start_q) begin
      busy_q <= 1'b1;
    end else if (stop_q) begin
      busy_q <= 1'b0;
    end
  end

  assign bus.scl_f_o    = scl_f_q;
  assign bus.sda_f_o    = sda_f_q;
  assign bus.scl_rise_o = scl_rise_q;
  assign bus.scl_fall_o = scl_fall_q;
  assign bus.start_o    = start_q;
  assign bus.stop_o     = stop_q;
  assign bus.busy_o     = busy_q;
  assign bus.sample_o   = sample_q;

endmodule

// File: tb/tb_i2c_bus_filter.sv
// Testbench for i2c_bus_filter: directed scenario tasks plus a randomized run
// compared cycle by cycle against a sample-window reference model.
module tb_i2c_bus_filter;
  localparam int DFSR_W = 16;

  logic              sysclk_i = 1'b0;
  logic              reset_i;
  logic              enable_i;
  logic [DFSR_W-1:0] dfsr_i;

  int checks   = 0;
  int failures = 0;

  i2c_bus_filter_if bus ();

  i2c_bus_filter #(.DFSR_W(DFSR_W)) dut (
    .sysclk_i (sysclk_i),
    .reset_i  (reset_i),
    .enable_i (enable_i),
    .dfsr_i   (dfsr_i),
    .bus      (bus.slave)
  );

  // Clock
  always #5 sysclk_i = ~sysclk_i;

  // Output vector order: {scl_f, sda_f, rise, fall, start, stop, busy, sample}
  function automatic logic [7:0] dut_vec();
    return {bus.scl_f_o, bus.sda_f_o, bus.scl_rise_o, bus.scl_fall_o,
            bus.start_o, bus.stop_o, bus.busy_o, bus.sample_o};
  endfunction

  // ---------------- reference model ----------------
  // Samples are taken at absolute edge numbers: P edges after the last
  // disabled/reset edge, then every P (the P in force at that sample) after.
  // Each line keeps a window of its last three samples; the filtered level is
  // the value held by at least two of them.
  longint m_edge = 0;
  longint m_next = 0;
  bit     m_scl_d1 = 1'b1, m_scl_d2 = 1'b1, m_sda_d1 = 1'b1, m_sda_d2 = 1'b1;
  bit     scl_win[$] = '{1'b1, 1'b1, 1'b1};
  bit     sda_win[$] = '{1'b1, 1'b1, 1'b1};
  logic   exp_scl_f = 1'b1, exp_sda_f = 1'b1, exp_rise = 1'b0, exp_fall = 1'b0;
  logic   exp_start = 1'b0, exp_stop = 1'b0, exp_busy = 1'b0, exp_sample = 1'b0;

  function automatic int period_of(logic [DFSR_W-1:0] d);
    return (d == '0) ? 1 : int'(d);
  endfunction

  always @(posedge sysclk_i) begin
    bit scl_s, sda_s, n_scl, n_sda, smp;
    int c_scl, c_sda;
    // the value a sample sees is the pad level from two edges ago
    scl_s = m_scl_d2;
    sda_s = m_sda_d2;
    m_scl_d2 = m_scl_d1;
    m_sda_d2 = m_sda_d1;
    m_scl_d1 = bus.scl_i;
    m_sda_d1 = bus.sda_i;
    smp = enable_i && !reset_i && (m_edge == m_next);
    if (reset_i) begin
      m_scl_d1 = 1'b1; m_scl_d2 = 1'b1; m_sda_d1 = 1'b1; m_sda_d2 = 1'b1;
    end
    if (reset_i || !enable_i) begin
      scl_win = '{1'b1, 1'b1, 1'b1};
      sda_win = '{1'b1, 1'b1, 1'b1};
      exp_scl_f = 1'b1; exp_sda_f = 1'b1;
      exp_rise = 1'b0; exp_fall = 1'b0; exp_start = 1'b0; exp_stop = 1'b0;
      exp_busy = 1'b0; exp_sample = 1'b0;
      m_next = m_edge + period_of(dfsr_i);
    end else begin
      if (exp_start) exp_busy = 1'b1;
      else if (exp_stop) exp_busy = 1'b0;
      exp_sample = smp;
      exp_rise = 1'b0; exp_fall = 1'b0; exp_start = 1'b0; exp_stop = 1'b0;
      if (smp) begin
        scl_win.push_back(scl_s); void'(scl_win.pop_front());
        sda_win.push_back(sda_s); void'(sda_win.pop_front());
        c_scl = 0; c_sda = 0;
        foreach (scl_win[i]) c_scl += int'(scl_win[i]);
        foreach (sda_win[i]) c_sda += int'(sda_win[i]);
        n_scl = (c_scl >= 2);
        n_sda = (c_sda >= 2);
        exp_rise  = !exp_scl_f && n_scl;
        exp_fall  = exp_scl_f && !n_scl;
        exp_start = exp_scl_f && n_scl && exp_sda_f && !n_sda;
        exp_stop  = exp_scl_f && n_scl && !exp_sda_f && n_sda;
        exp_scl_f = n_scl;
        exp_sda_f = n_sda;
        m_next = m_edge + period_of(dfsr_i);
      end
    end
    m_edge++;
  end

  // ---------------- scenario tasks ----------------
  task automatic test_reset();
    reset_i = 1'b1; enable_i = 1'b1; dfsr_i = 1;
    bus.scl_i = 1'b1; bus.sda_i = 1'b1;
    repeat (2) @(negedge sysclk_i);
    checks++;
    if (dut_vec() !== 8'b1100_0000) begin
      failures++;
      $display("FAIL reset_values: got %b expected %b", dut_vec(), 8'b1100_0000);
    end
    reset_i = 1'b0;
  endtask

  task automatic test_start_latency();
    repeat (8) @(negedge sysclk_i);
    bus.sda_i = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge sysclk_i);
      checks++;
      if (k < 4) begin
        if (bus.sda_f_o !== 1'b1 || bus.start_o !== 1'b0) begin
          failures++;
          $display("FAIL start_early cycle %0d: sda_f=%b start=%b expected 1 0", k, bus.sda_f_o, bus.start_o);
        end
      end else if (bus.sda_f_o !== 1'b0 || bus.start_o !== 1'b1 || bus.busy_o !== 1'b0) begin
        failures++;
        $display("FAIL start_at_4: sda_f=%b start=%b busy=%b expected 0 1 0", bus.sda_f_o, bus.start_o, bus.busy_o);
      end
    end
    @(negedge sysclk_i);
    checks++;
    if (bus.busy_o !== 1'b1 || bus.start_o !== 1'b0) begin
      failures++;
      $display("FAIL busy_after_start: busy=%b start=%b expected 1 0", bus.busy_o, bus.start_o);
    end
  endtask

  task automatic test_glitch_filter();
    bit found;
    bit low_seen;
    int per, falls, rises;
    dfsr_i = 24;
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(negedge sysclk_i); found = bus.sample_o;
    end
    per = 0; found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(negedge sysclk_i); per++; found = bus.sample_o;
    end
    checks++;
    if (!found || per != 24) begin
      failures++;
      $display("FAIL sample_period_24: got %0d (found=%0d) expected 24", per, found);
    end
    // single-cycle low glitch on SCL
    bus.scl_i = 1'b0;
    @(negedge sysclk_i);
    bus.scl_i = 1'b1;
    falls = 0; low_seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge sysclk_i);
      if (bus.scl_fall_o) falls++;
      if (!bus.scl_f_o) low_seen = 1'b1;
    end
    checks++;
    if (falls != 0) begin
      failures++;
      $display("FAIL glitch_no_fall: got %0d falls expected 0", falls);
    end
    checks++;
    if (low_seen) begin
      failures++;
      $display("FAIL glitch_scl_f: scl_f went low, expected to stay 1");
    end
    // 60-cycle low pulse
    bus.scl_i = 1'b0;
    falls = 0; rises = 0;
    for (int i = 0; i < 160; i++) begin
      @(negedge sysclk_i);
      if (bus.scl_fall_o) falls++;
      if (bus.scl_rise_o) rises++;
      if (i == 59) bus.scl_i = 1'b1;
    end
    checks++;
    if (falls != 1 || rises != 1 || bus.scl_f_o !== 1'b1) begin
      failures++;
      $display("FAIL pulse_60: falls=%0d rises=%0d scl_f=%b expected 1 1 1", falls, rises, bus.scl_f_o);
    end
  endtask

  task automatic test_stop_and_simultaneous();
    int conds, falls, rises;
    bit busy_seen;
    dfsr_i = 1;
    repeat (40) @(negedge sysclk_i);
    checks++;
    if (bus.busy_o !== 1'b1) begin
      failures++;
      $display("FAIL busy_held: got %b expected 1", bus.busy_o);
    end
    bus.sda_i = 1'b1;
    repeat (4) @(negedge sysclk_i);
    checks++;
    if (bus.stop_o !== 1'b1 || bus.sda_f_o !== 1'b1 || bus.busy_o !== 1'b1) begin
      failures++;
      $display("FAIL stop_at_4: stop=%b sda_f=%b busy=%b expected 1 1 1", bus.stop_o, bus.sda_f_o, bus.busy_o);
    end
    @(negedge sysclk_i);
    checks++;
    if (bus.busy_o !== 1'b0 || bus.stop_o !== 1'b0) begin
      failures++;
      $display("FAIL busy_after_stop: busy=%b stop=%b expected 0 0", bus.busy_o, bus.stop_o);
    end
    repeat (10) @(negedge sysclk_i);
    bus.scl_i = 1'b0; bus.sda_i = 1'b0;
    conds = 0; falls = 0; rises = 0; busy_seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge sysclk_i);
      if (bus.start_o || bus.stop_o) conds++;
      if (bus.scl_fall_o) falls++;
      if (bus.scl_rise_o) rises++;
      if (bus.busy_o) busy_seen = 1'b1;
      if (i == 19) begin bus.scl_i = 1'b1; bus.sda_i = 1'b1; end
    end
    checks++;
    if (conds != 0 || busy_seen) begin
      failures++;
      $display("FAIL simultaneous_no_cond: got %0d conditions busy_seen=%0d expected 0 0", conds, busy_seen);
    end
    checks++;
    if (falls != 1 || rises != 1) begin
      failures++;
      $display("FAIL simultaneous_edges: falls=%0d rises=%0d expected 1 1", falls, rises);
    end
  endtask

  task automatic test_dfsr_change();
    bit found;
    int per;
    int want [3] = '{24, 8, 8};
    dfsr_i = 24;
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(negedge sysclk_i); found = bus.sample_o;
    end
    for (int n = 0; n < 3; n++) begin
      per = 0; found = 1'b0;
      for (int i = 0; i < 100 && !found; i++) begin
        @(negedge sysclk_i); per++;
        if (n == 0 && per == 5) dfsr_i = 8;
        found = bus.sample_o;
      end
      checks++;
      if (!found || per != want[n]) begin
        failures++;
        $display("FAIL dfsr_change period %0d: got %0d expected %0d", n, per, want[n]);
      end
    end
  endtask

  task automatic test_reset_busy();
    bit found;
    int per, stops, idle_bad;
    dfsr_i = 1;
    repeat (30) @(negedge sysclk_i);
    bus.sda_i = 1'b0;
    repeat (8) @(negedge sysclk_i);
    checks++;
    if (bus.busy_o !== 1'b1) begin
      failures++;
      $display("FAIL busy_before_reset: got %b expected 1", bus.busy_o);
    end
    bus.scl_i = 1'b0;
    repeat (8) @(negedge sysclk_i);
    reset_i = 1'b1;
    @(negedge sysclk_i);
    checks++;
    if (dut_vec() !== 8'b1100_0000) begin
      failures++;
      $display("FAIL reset_mid_transfer: got %b expected %b", dut_vec(), 8'b1100_0000);
    end
    stops = 0;
    repeat (3) begin
      @(negedge sysclk_i);
      if (bus.stop_o) stops++;
    end
    reset_i = 1'b0; enable_i = 1'b0;
    idle_bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge sysclk_i);
      if (bus.stop_o) stops++;
      if (dut_vec() !== 8'b1100_0000) idle_bad++;
      if (i == 18) dfsr_i = 5;
    end
    checks++;
    if (stops != 0) begin
      failures++;
      $display("FAIL reset_no_stop: got %0d stop pulses expected 0", stops);
    end
    checks++;
    if (idle_bad != 0) begin
      failures++;
      $display("FAIL disabled_idle: got %0d non-idle cycles expected 0", idle_bad);
    end
    enable_i = 1'b1;
    per = 0; found = 1'b0;
    for (int i = 0; i < 50 && !found; i++) begin
      @(negedge sysclk_i); per++; found = bus.sample_o;
    end
    checks++;
    if (!found || per != 5) begin
      failures++;
      $display("FAIL first_sample_after_enable: got %0d expected 5", per);
    end
    bus.scl_i = 1'b1; bus.sda_i = 1'b1;
  endtask

  task automatic test_random();
    logic [7:0] got, exp;
    int bad;
    bad = 0;
    reset_i = 1'b1;
    @(negedge sysclk_i);
    reset_i = 1'b0; enable_i = 1'b1; dfsr_i = DFSR_W'($urandom_range(0, 4));
    for (int c = 0; c < 4000; c++) begin
      @(negedge sysclk_i);
      got = dut_vec();
      exp = {exp_scl_f, exp_sda_f, exp_rise, exp_fall, exp_start, exp_stop, exp_busy, exp_sample};
      checks++;
      if (got !== exp) begin
        failures++;
        if (bad < 10) $display("FAIL random cycle %0d: got %b expected %b", c, got, exp);
        bad++;
      end
      reset_i = 1'b0;
      if ($urandom_range(0, 12) == 0) bus.scl_i = ~bus.scl_i;
      if ($urandom_range(0, 14) == 0) bus.sda_i = ~bus.sda_i;
      if ($urandom_range(0, 399) == 0) dfsr_i = DFSR_W'($urandom_range(0, 4));
      if ($urandom_range(0, 999) == 0) reset_i = 1'b1;
      if (enable_i ? ($urandom_range(0, 599) == 0) : ($urandom_range(0, 9) == 0))
        enable_i = ~enable_i;
    end
  endtask

  // Watchdog
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_start_latency();
    test_glitch_filter();
    test_stop_and_simultaneous();
    test_dfsr_change();
    test_reset_busy();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
